// File: rtl/oled_pkg.sv
// Shared definitions for OLED page writers: SSD1306/SH1106 control bytes,
// writer FSM states and the 24-bit {slave, control, payload} frame word.
package oled_pkg;

  localparam logic [7:0] OLED_CTRL_CMD   = 8'h00;
  localparam logic [7:0] OLED_CTRL_DATA  = 8'h40;
  localparam logic [7:0] OLED_CMD_PAGE   = 8'hB0;
  localparam logic [7:0] OLED_CMD_COL_HI = 8'h10;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    CMD_PAGE   = 3'd1,
    CMD_COL_LO = 3'd2,
    CMD_COL_HI = 3'd3,
    DATA       = 3'd4,
    DONE       = 3'd5
  } oled_state_e;

  typedef logic [23:0] oled_frame_t;

  // Checkerboard inverts the pattern on cells where column and page parity differ
  function automatic logic [7:0] oled_data_byte(input logic [7:0] pattern,
                                                input logic       checker_en,
                                                input logic       col_lsb,
                                                input logic       page_lsb);
    if (checker_en && (col_lsb ^ page_lsb)) begin
      return ~pattern;
    end else begin
      return pattern;
    end
  endfunction

endpackage

// File: rtl/oled_frame_fmt.sv
// Combinational frame formatter: maps writer state, page, column and pattern
// to the 24-bit word handed to the IIC byte writer. Idle states yield zero.
module oled_frame_fmt
  import oled_pkg::*;
#(
  parameter logic [7:0] SLAVE_ADDR = 8'h78,
  parameter int         COL_OFFSET = 0
) (
  input  oled_state_e state,
  input  logic [2:0]  page,
  input  logic [7:0]  pattern,
  input  logic        col_lsb,
  input  logic        checker_en,
  output oled_frame_t frame
);

  localparam logic [6:0] COL_OFF     = 7'(COL_OFFSET);
  localparam logic [7:0] COL_LO_BYTE = {4'h0, COL_OFF[3:0]};
  localparam logic [7:0] COL_HI_BYTE = OLED_CMD_COL_HI | {5'h00, COL_OFF[6:4]};

  // Select the frame word for the byte about to be sent
  always_comb begin
    frame = 24'h000000;
    case (state)
      CMD_PAGE:   frame = {SLAVE_ADDR, OLED_CTRL_CMD, OLED_CMD_PAGE | {5'h00, page}};
      CMD_COL_LO: frame = {SLAVE_ADDR, OLED_CTRL_CMD, COL_LO_BYTE};
      CMD_COL_HI: frame = {SLAVE_ADDR, OLED_CTRL_CMD, COL_HI_BYTE};
      DATA:       frame = {SLAVE_ADDR, OLED_CTRL_DATA,
                           oled_data_byte(pattern, checker_en, col_lsb, page[0])};
      default:    frame = 24'h000000;
    endcase
  end

endmodule

// File: rtl/oled_fill_engine.sv
// Fills a page range of an SSD1306/SH1106 OLED with a byte pattern, one IIC
// frame per write_done. Define OLED_FILL_CHECKER_EN to add the checkerboard input.
module oled_fill_engine
  import oled_pkg::*;
#(
  parameter logic [7:0] SLAVE_ADDR = 8'h78,
  parameter int         PAGES      = 8,
  parameter int         COLS       = 128,
  parameter int         COL_OFFSET = 0
) (
  input  logic        clk_50m,
  input  logic        rst_n,
  input  logic        fill_req,
  input  logic [7:0]  fill_pattern,
  input  logic [2:0]  page_first,
  input  logic [2:0]  page_last,
`ifdef OLED_FILL_CHECKER_EN
  input  logic        fill_checker,
`endif
  input  logic        write_done,
  output logic        write_req,
  output logic [23:0] fill_data,
  output logic        busy,
  output logic        fill_finish
);

  localparam int               COL_W    = $clog2(COLS + 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);

  oled_state_e      state_r, nxt_state_s;
  logic [2:0]       page_r, nxt_page_s, last_r, nxt_last_s;
  logic [2:0]       first_clamp_s, last_clamp_s;
  logic [COL_W-1:0] col_r, nxt_col_s;
  logic [7:0]       pattern_r, nxt_pattern_s;
  logic             checker_r, nxt_checker_s, checker_in_s;
  logic             frame_start_s;
  oled_frame_t      frame_s;
  logic             write_req_r, busy_r, finish_r;
  logic [23:0]      fill_data_r;

`ifdef OLED_FILL_CHECKER_EN
  assign checker_in_s = fill_checker;
`else
  assign checker_in_s = 1'b0;
`endif

  function automatic logic [2:0] clamp_page(input logic [2:0] p);
    if ({1'b0, p} >= 4'(PAGES)) begin
      return 3'(PAGES - 1);
    end else begin
      return p;
    end
  endfunction

  // Clamp the requested page range; an inverted range collapses to page_first
  always_comb begin
    first_clamp_s = clamp_page(page_first);
    last_clamp_s  = clamp_page(page_last);
    if (last_clamp_s < first_clamp_s) begin
      last_clamp_s = first_clamp_s;
    end else begin
      last_clamp_s = last_clamp_s;
    end
  end

  // Next-state logic: every byte state advances only on write_done
  always_comb begin
    nxt_state_s   = state_r;
    nxt_page_s    = page_r;
    nxt_last_s    = last_r;
    nxt_col_s     = col_r;
    nxt_pattern_s = pattern_r;
    nxt_checker_s = checker_r;
    case (state_r)
      IDLE: begin
        if (fill_req) begin
          nxt_state_s   = CMD_PAGE;
          nxt_page_s    = first_clamp_s;
          nxt_last_s    = last_clamp_s;
          nxt_col_s     = {COL_W{1'b0}};
          nxt_pattern_s = fill_pattern;
          nxt_checker_s = checker_in_s;
        end else begin
          nxt_state_s = IDLE;
        end
      end
      CMD_PAGE: begin
        if (write_done) nxt_state_s = CMD_COL_LO;
        else            nxt_state_s = CMD_PAGE;
      end
      CMD_COL_LO: begin
        if (write_done) nxt_state_s = CMD_COL_HI;
        else            nxt_state_s = CMD_COL_LO;
      end
      CMD_COL_HI: begin
        if (write_done) begin
          nxt_state_s = DATA;
          nxt_col_s   = {COL_W{1'b0}};
        end else begin
          nxt_state_s = CMD_COL_HI;
        end
      end
      DATA: begin
        if (!write_done) begin
          nxt_state_s = DATA;
        end else if (col_r != COL_LAST) begin
          nxt_col_s = col_r + COL_W'(1);
        end else if (page_r < last_r) begin
          nxt_state_s = CMD_PAGE;
          nxt_page_s  = page_r + 3'd1;
          nxt_col_s   = {COL_W{1'b0}};
        end else begin
          nxt_state_s = DONE;
        end
      end
      DONE:    nxt_state_s = IDLE;
      default: nxt_state_s = IDLE;
    endcase
  end

  // A new frame starts whenever the FSM lands on a fresh byte state or column
  assign frame_start_s = ((nxt_state_s != state_r) || (nxt_col_s != col_r)) &&
                         (nxt_state_s != IDLE) && (nxt_state_s != DONE);

  oled_frame_fmt #(
    .SLAVE_ADDR (SLAVE_ADDR),
    .COL_OFFSET (COL_OFFSET)
  ) u_fmt (
    .state      (nxt_state_s),
    .page       (nxt_page_s),
    .pattern    (nxt_pattern_s),
    .col_lsb    (nxt_col_s[0]),
    .checker_en (nxt_checker_s),
    .frame      (frame_s)
  );

  // State, counters and registered outputs
  always_ff @(posedge clk_50m) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      page_r      <= 3'd0;
      last_r      <= 3'd0;
      col_r       <= {COL_W{1'b0}};
      pattern_r   <= 8'h00;
      checker_r   <= 1'b0;
      write_req_r <= 1'b0;
      busy_r      <= 1'b0;
      finish_r    <= 1'b0;
      fill_data_r <= 24'h000000;
    end else begin
      state_r     <= nxt_state_s;
      page_r      <= nxt_page_s;
      last_r      <= nxt_last_s;
      col_r       <= nxt_col_s;
      pattern_r   <= nxt_pattern_s;
      checker_r   <= nxt_checker_s;
      write_req_r <= frame_start_s;
      busy_r      <= (nxt_state_s != IDLE) && (nxt_state_s != DONE);
      finish_r    <= (nxt_state_s == DONE);
      fill_data_r <= frame_s;
    end
  end

  assign write_req   = write_req_r;
  assign fill_data   = fill_data_r;
  assign busy        = busy_r;
  assign fill_finish = finish_r;

endmodule

// File: tb/tb_oled_fill_engine.sv
// Directed bench for oled_fill_engine: three instances (default, COLS=4,
// COLS=4/COL_OFFSET=2/PAGES=4) share stimulus, each with its own IIC responder.
module tb_oled_fill_engine;
  import oled_pkg::*;

  logic        clk_50m = 1'b0;
  logic        rst_n;
  logic        fill_req;
  logic [7:0]  fill_pattern;
  logic [2:0]  page_first;
  logic [2:0]  page_last;
  logic        write_done_v  [3];
  logic        write_req_v   [3];
  logic [23:0] fill_data_v   [3];
  logic        busy_v        [3];
  logic        fill_finish_v [3];

  int          lat [3];
  int          wait_ctr [3];
  logic [23:0] frames [3][$];
  int          req_cnt [3];
  int          done_cnt [3];
  int          fin_cnt [3];
  int          last_wd_cyc [3];
  int          fin_cyc [3];
  int          cyc = 0;
  int          checks = 0;
  int          passed = 0;

  always #10 clk_50m = ~clk_50m;

  always @(posedge clk_50m) cyc <= cyc + 1;

  oled_fill_engine dut_a (
    .clk_50m(clk_50m), .rst_n(rst_n), .fill_req(fill_req), .fill_pattern(fill_pattern),
    .page_first(page_first), .page_last(page_last), .write_done(write_done_v[0]),
    .write_req(write_req_v[0]), .fill_data(fill_data_v[0]), .busy(busy_v[0]),
    .fill_finish(fill_finish_v[0]));

  oled_fill_engine #(.COLS(4)) dut_b (
    .clk_50m(clk_50m), .rst_n(rst_n), .fill_req(fill_req), .fill_pattern(fill_pattern),
    .page_first(page_first), .page_last(page_last), .write_done(write_done_v[1]),
    .write_req(write_req_v[1]), .fill_data(fill_data_v[1]), .busy(busy_v[1]),
    .fill_finish(fill_finish_v[1]));

  oled_fill_engine #(.PAGES(4), .COLS(4), .COL_OFFSET(2)) dut_c (
    .clk_50m(clk_50m), .rst_n(rst_n), .fill_req(fill_req), .fill_pattern(fill_pattern),
    .page_first(page_first), .page_last(page_last), .write_done(write_done_v[2]),
    .write_req(write_req_v[2]), .fill_data(fill_data_v[2]), .busy(busy_v[2]),
    .fill_finish(fill_finish_v[2]));

  // IIC writer model: records each frame and answers after lat[g] cycles
  initial begin
    for (int g = 0; g < 3; g++) begin
      write_done_v[g] = 1'b0;
      wait_ctr[g] = 0;
    end
    forever begin
      @(negedge clk_50m);
      for (int g = 0; g < 3; g++) begin
        write_done_v[g] = 1'b0;
        if (wait_ctr[g] > 0) begin
          wait_ctr[g] = wait_ctr[g] - 1;
          if (wait_ctr[g] == 0) write_done_v[g] = 1'b1;
        end else if (write_req_v[g] === 1'b1) begin
          frames[g].push_back(fill_data_v[g]);
          if (lat[g] == 0) write_done_v[g] = 1'b1;
          else wait_ctr[g] = lat[g];
        end
      end
    end
  end

  // Event counters, sampled just after the responder has acted
  initial begin
    for (int g = 0; g < 3; g++) begin
      req_cnt[g] = 0; done_cnt[g] = 0; fin_cnt[g] = 0;
      last_wd_cyc[g] = 0; fin_cyc[g] = 0;
    end
    forever begin
      @(negedge clk_50m);
      #1;
      for (int g = 0; g < 3; g++) begin
        if (write_req_v[g] === 1'b1) req_cnt[g] = req_cnt[g] + 1;
        if (write_done_v[g] === 1'b1) begin
          done_cnt[g] = done_cnt[g] + 1;
          last_wd_cyc[g] = cyc;
        end
        if (fill_finish_v[g] === 1'b1) begin
          fin_cnt[g] = fin_cnt[g] + 1;
          fin_cyc[g] = cyc;
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk_50m);
    #2;
  endtask

  task automatic start_fill(input logic [7:0] pat, input logic [2:0] first, input logic [2:0] last);
    fill_pattern = pat;
    page_first   = first;
    page_last    = last;
    fill_req     = 1'b1;
    tick();
    fill_req     = 1'b0;
  endtask

  task automatic wait_fin(input int g, input int fin0, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      tick();
      if (fin_cnt[g] > fin0) ok = 1'b1;
    end
  endtask

  task automatic settle(output bit ok);
    int quiet;
    quiet = 0;
    ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      tick();
      if (busy_v[0] === 1'b0 && busy_v[1] === 1'b0 && busy_v[2] === 1'b0) quiet++;
      else quiet = 0;
      if (quiet >= 3) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; fill_req = 1'b0; fill_pattern = 8'h00; page_first = 3'd0; page_last = 3'd0;
    for (int g = 0; g < 3; g++) lat[g] = 0;
    repeat (3) tick();
    checks++; if (write_req_v[0] !== 1'b0) $display("FAIL reset_write_req got=%b exp=0", write_req_v[0]); else passed++;
    checks++; if (busy_v[0] !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy_v[0]); else passed++;
    checks++; if (fill_finish_v[0] !== 1'b0) $display("FAIL reset_finish got=%b exp=0", fill_finish_v[0]); else passed++;
    checks++; if (fill_data_v[0] !== 24'h000000) $display("FAIL reset_data got=%h exp=000000", fill_data_v[0]); else passed++;
    checks++; if (dut_a.state_r !== IDLE) $display("FAIL reset_state got=%0d exp=IDLE", dut_a.state_r); else passed++;
    rst_n = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_full_default();
    int fb, rq0, dn0, fn0;
    bit ok;
    fb = frames[0].size(); rq0 = req_cnt[0]; dn0 = done_cnt[0]; fn0 = fin_cnt[0];
    start_fill(8'h00, 3'd0, 3'd7);
    wait_fin(0, fn0, 3000, ok);
    checks++; if (!ok) $display("FAIL full_timeout no fill_finish within budget"); else passed++;
    checks++; if (frames[0].size() - fb != 1048) $display("FAIL full_frames got=%0d exp=1048", frames[0].size() - fb); else passed++;
    checks++; if (req_cnt[0] - rq0 != 1048) $display("FAIL full_reqs got=%0d exp=1048", req_cnt[0] - rq0); else passed++;
    checks++; if (done_cnt[0] - dn0 != 1048) $display("FAIL full_dones got=%0d exp=1048", done_cnt[0] - dn0); else passed++;
    checks++; if (frames[0][fb] !== 24'h7800B0) $display("FAIL full_f0 got=%h exp=7800B0", frames[0][fb]); else passed++;
    checks++; if (frames[0][fb+1] !== 24'h780000) $display("FAIL full_f1 got=%h exp=780000", frames[0][fb+1]); else passed++;
    checks++; if (frames[0][fb+2] !== 24'h780010) $display("FAIL full_f2 got=%h exp=780010", frames[0][fb+2]); else passed++;
    checks++; if (frames[0][fb+3] !== 24'h784000) $display("FAIL full_f3 got=%h exp=784000", frames[0][fb+3]); else passed++;
    checks++; if (frames[0][fb+917] !== 24'h7800B7) $display("FAIL full_p7 got=%h exp=7800B7", frames[0][fb+917]); else passed++;
    checks++; if (fin_cyc[0] - last_wd_cyc[0] != 1) $display("FAIL full_fin_lat got=%0d exp=1", fin_cyc[0] - last_wd_cyc[0]); else passed++;
    checks++; if (busy_v[0] !== 1'b0) $display("FAIL full_busy_end got=%b exp=0", busy_v[0]); else passed++;
    repeat (5) tick();
    checks++; if (fin_cnt[0] - fn0 != 1) $display("FAIL full_fin_count got=%0d exp=1", fin_cnt[0] - fn0); else passed++;
  endtask

  task automatic test_pattern_range();
    logic [23:0] exp_b [14] = '{24'h7800B2, 24'h780000, 24'h780010, 24'h7840A5, 24'h7840A5,
                                24'h7840A5, 24'h7840A5, 24'h7800B3, 24'h780000, 24'h780010,
                                24'h7840A5, 24'h7840A5, 24'h7840A5, 24'h7840A5};
    int fb, fn0, low_busy;
    bit ok;
    fb = frames[1].size(); fn0 = fin_cnt[1]; low_busy = 0;
    start_fill(8'hA5, 3'd2, 3'd3);
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      if (fin_cnt[1] > fn0) ok = 1'b1;
      else if (busy_v[1] !== 1'b1) low_busy++;
      if (!ok) tick();
    end
    checks++; if (!ok) $display("FAIL range_timeout no fill_finish within budget"); else passed++;
    checks++; if (low_busy != 0) $display("FAIL range_busy low_cycles=%0d exp=0", low_busy); else passed++;
    checks++; if (frames[1].size() - fb != 14) $display("FAIL range_frames got=%0d exp=14", frames[1].size() - fb); else passed++;
    for (int i = 0; i < 14; i++) begin
      checks++;
      if (frames[1][fb+i] !== exp_b[i]) $display("FAIL range_f%0d got=%h exp=%h", i, frames[1][fb+i], exp_b[i]);
      else passed++;
    end
    tick();
    checks++; if (busy_v[1] !== 1'b0) $display("FAIL range_busy_end got=%b exp=0", busy_v[1]); else passed++;
  endtask

  task automatic test_col_offset();
    int fb, fn0;
    bit ok;
    logic [23:0] exp_pg;
    fb = frames[2].size(); fn0 = fin_cnt[2];
    start_fill(8'h3C, 3'd1, 3'd6);
    wait_fin(2, fn0, 200, ok);
    checks++; if (!ok) $display("FAIL offset_timeout no fill_finish within budget"); else passed++;
    checks++; if (frames[2].size() - fb != 21) $display("FAIL offset_frames got=%0d exp=21", frames[2].size() - fb); else passed++;
    exp_pg = 24'h7800B1;
    for (int p = 0; p < 3; p++) begin
      checks++; if (frames[2][fb+7*p] !== exp_pg) $display("FAIL offset_page%0d got=%h exp=%h", p, frames[2][fb+7*p], exp_pg); else passed++;
      checks++; if (frames[2][fb+7*p+1] !== 24'h780002) $display("FAIL offset_lo%0d got=%h exp=780002", p, frames[2][fb+7*p+1]); else passed++;
      checks++; if (frames[2][fb+7*p+2] !== 24'h780010) $display("FAIL offset_hi%0d got=%h exp=780010", p, frames[2][fb+7*p+2]); else passed++;
      checks++; if (frames[2][fb+7*p+6] !== 24'h78403C) $display("FAIL offset_data%0d got=%h exp=78403C", p, frames[2][fb+7*p+6]); else passed++;
      exp_pg = exp_pg + 24'h000001;
    end
  endtask

  task automatic test_clamp();
    int fb, fn0;
    bit ok;
    fb = frames[0].size(); fn0 = fin_cnt[0];
    start_fill(8'h5A, 3'd5, 3'd1);
    wait_fin(0, fn0, 400, ok);
    checks++; if (!ok) $display("FAIL clamp_timeout no fill_finish within budget"); else passed++;
    checks++; if (frames[0].size() - fb != 131) $display("FAIL clamp_frames got=%0d exp=131", frames[0].size() - fb); else passed++;
    checks++; if (frames[0][fb] !== 24'h7800B5) $display("FAIL clamp_f0 got=%h exp=7800B5", frames[0][fb]); else passed++;
    checks++; if (frames[0][fb+130] !== 24'h78405A) $display("FAIL clamp_last got=%h exp=78405A", frames[0][fb+130]); else passed++;
  endtask

  task automatic test_hold_and_ignore();
    int fb, rq0, fn0, unstable;
    bit ok;
    fb = frames[0].size(); rq0 = req_cnt[0]; fn0 = fin_cnt[0]; unstable = 0;
    lat[0] = 50;
    start_fill(8'hFF, 3'd0, 3'd0);
    for (int i = 0; i < 45; i++) begin
      if (fill_data_v[0] !== 24'h7800B0) unstable++;
      if (i == 20) begin
        page_first = 3'd7; page_last = 3'd7; fill_req = 1'b1;
      end else begin
        fill_req = 1'b0;
      end
      tick();
    end
    fill_req = 1'b0;
    checks++; if (unstable != 0) $display("FAIL hold_data unstable_cycles=%0d exp=0", unstable); else passed++;
    checks++; if (req_cnt[0] - rq0 != 1) $display("FAIL hold_reqs got=%0d exp=1", req_cnt[0] - rq0); else passed++;
    lat[0] = 0;
    wait_fin(0, fn0, 400, ok);
    checks++; if (!ok) $display("FAIL hold_timeout no fill_finish within budget"); else passed++;
    repeat (20) tick();
    checks++; if (req_cnt[0] - rq0 != 131) $display("FAIL ignore_reqs got=%0d exp=131", req_cnt[0] - rq0); else passed++;
    checks++; if (frames[0][fb+131] !== 24'h000000 && frames[0].size() > fb + 131)
      $display("FAIL ignore_queued got=%h exp=none", frames[0][fb+131]); else passed++;
    checks++; if (fin_cnt[0] - fn0 != 1) $display("FAIL ignore_fin got=%0d exp=1", fin_cnt[0] - fn0); else passed++;
  endtask

  task automatic test_reset_abort();
    int fb, rq0, fn0;
    bit ok;
    fb = frames[0].size();
    start_fill(8'h11, 3'd3, 3'd4);
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      if (frames[0].size() - fb >= 13) ok = 1'b1;
      else tick();
    end
    checks++; if (!ok) $display("FAIL abort_timeout tenth data byte not reached"); else passed++;
    rst_n = 1'b0;
    tick();
    checks++; if (write_req_v[0] !== 1'b0) $display("FAIL abort_write_req got=%b exp=0", write_req_v[0]); else passed++;
    checks++; if (busy_v[0] !== 1'b0) $display("FAIL abort_busy got=%b exp=0", busy_v[0]); else passed++;
    checks++; if (fill_finish_v[0] !== 1'b0) $display("FAIL abort_finish got=%b exp=0", fill_finish_v[0]); else passed++;
    checks++; if (fill_data_v[0] !== 24'h000000) $display("FAIL abort_data got=%h exp=000000", fill_data_v[0]); else passed++;
    checks++; if (dut_a.state_r !== IDLE) $display("FAIL abort_state got=%0d exp=IDLE", dut_a.state_r); else passed++;
    rst_n = 1'b1;
    rq0 = req_cnt[0];
    repeat (10) tick();
    checks++; if (req_cnt[0] != rq0) $display("FAIL abort_quiet got=%0d exp=0", req_cnt[0] - rq0); else passed++;
    fb = frames[0].size(); fn0 = fin_cnt[0];
    start_fill(8'h22, 3'd4, 3'd5);
    checks++; if (frames[0][fb] !== 24'h7800B4) $display("FAIL restart_f0 got=%h exp=7800B4", frames[0][fb]); else passed++;
    wait_fin(0, fn0, 600, ok);
    checks++; if (frames[0].size() - fb != 262) $display("FAIL restart_frames got=%0d exp=262", frames[0].size() - fb); else passed++;
  endtask

  initial begin
    bit ok;
    test_reset();
    test_full_default();
    settle(ok);
    checks++; if (!ok) $display("FAIL settle_1 instances still busy"); else passed++;
    test_pattern_range();
    settle(ok);
    test_col_offset();
    settle(ok);
    test_clamp();
    settle(ok);
    test_hold_and_ignore();
    settle(ok);
    checks++; if (!ok) $display("FAIL settle_2 instances still busy"); else passed++;
    test_reset_abort();
    settle(ok);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
